// File: rtl/tt_sweep_pkg.sv
// Shared types, sizes and the golden q_1 behaviour for the truth-table sweep controller.
package tt_sweep_pkg;

  localparam int NUM_VEC  = 8;
  localparam int RESULT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Reference q_1 behaviour indexed by {c,b,a}; c does not influence either output.
  function automatic logic golden_x(input logic [2:0] vec);
    return vec[0] | vec[1];
  endfunction

  function automatic logic golden_y(input logic [2:0] vec);
    return vec[0] | vec[1];
  endfunction

endpackage

// File: rtl/tt_golden.sv
// Combinational golden model of q_1: maps the driven vector {c,b,a} to expected x,y.
module tt_golden
  import tt_sweep_pkg::*;
(
  input  logic [2:0] vec,
  output logic       x_exp,
  output logic       y_exp
);

  assign x_exp = golden_x(vec);
  assign y_exp = golden_y(vec);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all eight {c,b,a} vectors into q_1 and packs the sampled x/y into a truth-table word.
// Optional self-check against the golden model is enabled with TT_SWEEP_CHECK_EN.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                x,
  input  logic                y,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] result,
  output logic [4:0]          ones
`ifdef TT_SWEEP_CHECK_EN
  ,
  output logic [3:0]          mismatch,
  output logic                err
`endif
);

  localparam logic [7:0] LAST_HOLD = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] LAST_IDX  = 3'(NUM_VEC - 1);

  state_e     state;
  logic [2:0] idx;
  logic [7:0] hold_cnt;
  logic [7:0] x_vec;
  logic [7:0] y_vec;
  logic       sample;
  logic       accept;

  // Abort outranks the sample that would otherwise land on the same edge.
  assign sample = (state == DRIVE) && !abort && (hold_cnt == LAST_HOLD);
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd0;
      hold_cnt <= 8'd0;
      x_vec    <= 8'd0;
      y_vec    <= 8'd0;
      ones     <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= DRIVE;
            idx      <= 3'd0;
            hold_cnt <= 8'd0;
            x_vec    <= 8'd0;
            y_vec    <= 8'd0;
            ones     <= 5'd0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state    <= IDLE;
            idx      <= 3'd0;
            hold_cnt <= 8'd0;
          end else if (sample) begin
            x_vec[idx] <= x;
            y_vec[idx] <= y;
            ones       <= ones + {4'd0, x} + {4'd0, y};
            hold_cnt   <= 8'd0;
            if (idx == LAST_IDX) begin
              state <= DONE;
              idx   <= 3'd0;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign {c, b, a} = idx;
  assign busy      = (state == DRIVE);
  assign done      = (state == DONE);
  assign result    = {y_vec, x_vec};

`ifdef TT_SWEEP_CHECK_EN
  logic x_exp;
  logic y_exp;

  tt_golden u_golden (
    .vec   (idx),
    .x_exp (x_exp),
    .y_exp (y_exp)
  );

  // Counts vectors whose captured x or y disagrees with the golden model, saturating at 8.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch <= 4'd0;
    end else if (accept) begin
      mismatch <= 4'd0;
    end else if (sample && ((x != x_exp) || (y != y_exp)) && (mismatch != 4'd8)) begin
      mismatch <= mismatch + 4'd1;
    end
  end

  assign err = (mismatch != 4'd0);
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: two lanes (H=2 and H=1) driven by a faultable q_1 model.
module tb_tt_sweep_ctrl;

  localparam int HOLD0 = 2;
  localparam int HOLD1 = 1;

  typedef struct packed {
    logic [15:0] result;
    logic [4:0]  ones;
    logic [3:0]  mism;
    int          done_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_s  [2];
  logic        abort_s  [2];
  logic        x_s      [2];
  logic        y_s      [2];
  logic        a_s      [2];
  logic        b_s      [2];
  logic        c_s      [2];
  logic        busy_s   [2];
  logic        done_s   [2];
  logic [15:0] result_s [2];
  logic [4:0]  ones_s   [2];
  logic [7:0]  fx_s     [2];
  logic [7:0]  fy_s     [2];
`ifdef TT_SWEEP_CHECK_EN
  logic [3:0]  mism_s   [2];
  logic        err_s    [2];
`endif

  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t exp_q [2][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Each lane is one DUT plus a q_1 stand-in whose outputs can be flipped per vector.
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned H = (g == 0) ? HOLD0 : HOLD1;

    tt_sweep_ctrl #(.HOLD_CYCLES(H)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s[g]),
      .abort    (abort_s[g]),
      .x        (x_s[g]),
      .y        (y_s[g]),
      .a        (a_s[g]),
      .b        (b_s[g]),
      .c        (c_s[g]),
      .busy     (busy_s[g]),
      .done     (done_s[g]),
      .result   (result_s[g]),
      .ones     (ones_s[g])
`ifdef TT_SWEEP_CHECK_EN
      ,
      .mismatch (mism_s[g]),
      .err      (err_s[g])
`endif
    );

    assign x_s[g] = (a_s[g] | b_s[g]) ^ fx_s[g][{c_s[g], b_s[g], a_s[g]}];
    assign y_s[g] = (a_s[g] | b_s[g]) ^ fy_s[g][{c_s[g], b_s[g], a_s[g]}];
  end

  function automatic int hold_of(input int ln);
    return (ln == 0) ? HOLD0 : HOLD1;
  endfunction

  // Truth table of a|b over the first n vectors, with faulty vectors flipped.
  function automatic exp_t model(input int n, input logic [7:0] fx, input logic [7:0] fy,
                                 input int done_cyc);
    exp_t       r;
    logic [7:0] xv;
    logic [7:0] yv;
    int         mm;
    xv = 8'd0;
    yv = 8'd0;
    mm = 0;
    for (int i = 0; i < n; i++) begin
      logic gold;
      gold  = ((i % 2) == 1) || (((i / 2) % 2) == 1);
      xv[i] = gold ^ fx[i];
      yv[i] = gold ^ fy[i];
      if (fx[i] || fy[i]) mm++;
    end
    r.result   = {yv, xv};
    r.ones     = 5'($countones({yv, xv}));
    r.mism     = 4'((mm > 8) ? 8 : mm);
    r.done_cyc = done_cyc;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int l = 0; l < 2; l++) begin
        if (done_s[l] === 1'b1) begin
          exp_t ex;
          n_tests++;
          if (exp_q[l].size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_done: lane %0d got done=1, expected 0 (cycle %0d)", l, cyc);
          end else begin
            ex = exp_q[l].pop_front();
            check_output("done_cycle", cyc, ex.done_cyc);
            check_output("result",     result_s[l], ex.result);
            check_output("ones",       ones_s[l], ex.ones);
            check_output("busy_at_done", busy_s[l], 1'b0);
`ifdef TT_SWEEP_CHECK_EN
            check_output("mismatch", mism_s[l], ex.mism);
            check_output("err",      err_s[l], ex.mism != 4'd0);
`endif
          end
        end
      end
    end
  end

  // One sweep on a lane, optionally aborted after three samples or poked with a stray start.
  task automatic apply_stimulus(input int ln, input bit do_abort, input bit extra,
                                input logic [7:0] fx, input logic [7:0] fy);
    int   h;
    int   e;
    exp_t part;
    h = hold_of(ln);
    @(negedge clk);
    fx_s[ln]    = fx;
    fy_s[ln]    = fy;
    start_s[ln] = 1'b1;
    e = cyc + 1;
    if (!do_abort) exp_q[ln].push_back(model(8, fx, fy, e + 8 * h));
    for (int j = 0; j <= 8 * h; j++) begin
      @(negedge clk);
      if (do_abort && (j == 3 * h + 1)) begin
        abort_s[ln] = 1'b0;
        part = model(3, fx, fy, 0);
        check_output("abort_busy",   busy_s[ln], 1'b0);
        check_output("abort_done",   done_s[ln], 1'b0);
        check_output("abort_vec",    {c_s[ln], b_s[ln], a_s[ln]}, 3'd0);
        check_output("abort_result", result_s[ln], part.result);
        check_output("abort_ones",   ones_s[ln], part.ones);
`ifdef TT_SWEEP_CHECK_EN
        check_output("abort_mismatch", mism_s[ln], part.mism);
`endif
        break;
      end
      if (j < 8 * h) begin
        check_output("busy", busy_s[ln], 1'b1);
        check_output("vector", {c_s[ln], b_s[ln], a_s[ln]}, j / h);
      end else begin
        check_output("busy_end", busy_s[ln], 1'b0);
      end
      start_s[ln] = extra && (j == 2);
      abort_s[ln] = do_abort && (j == 3 * h);
    end
    start_s[ln] = 1'b0;
    abort_s[ln] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int l = 0; l < 2; l++) begin
      check_output({tag, "_vec"},    {c_s[l], b_s[l], a_s[l]}, 3'd0);
      check_output({tag, "_busy"},   busy_s[l], 1'b0);
      check_output({tag, "_done"},   done_s[l], 1'b0);
      check_output({tag, "_result"}, result_s[l], 16'h0000);
      check_output({tag, "_ones"},   ones_s[l], 5'd0);
`ifdef TT_SWEEP_CHECK_EN
      check_output({tag, "_mismatch"}, mism_s[l], 4'd0);
      check_output({tag, "_err"},      err_s[l], 1'b0);
`endif
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation still running, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    for (int l = 0; l < 2; l++) begin
      start_s[l] = 1'b0;
      abort_s[l] = 1'b0;
      fx_s[l]    = 8'h00;
      fy_s[l]    = 8'h00;
    end
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    apply_stimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    apply_stimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
    apply_stimulus(0, 1'b0, 1'b0, 8'h20, 8'h00);
    apply_stimulus(1, 1'b0, 1'b0, 8'h20, 8'h00);
    apply_stimulus(0, 1'b1, 1'b0, 8'h00, 8'h00);
    apply_stimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    apply_stimulus(1, 1'b1, 1'b0, 8'h00, 8'h00);
    apply_stimulus(0, 1'b0, 1'b1, 8'h00, 8'h00);
    apply_stimulus(1, 1'b0, 1'b1, 8'h00, 8'h00);

    // Reset asserted between edges mid-sweep must clear everything without waiting for a clock.
    @(negedge clk);
    fx_s[0]    = 8'h00;
    fy_s[0]    = 8'h00;
    start_s[0] = 1'b1;
    exp_q[0].push_back(model(8, 8'h00, 8'h00, cyc + 1 + 8 * HOLD0));
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    for (int l = 0; l < 2; l++) exp_q[l].delete();
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);

    for (int k = 0; k < 16; k++) begin
      int         ln;
      int         op;
      logic [7:0] fx;
      logic [7:0] fy;
      ln = $urandom_range(0, 1);
      op = $urandom_range(0, 3);
      fx = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      fy = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      apply_stimulus(ln, op == 1, op == 2, fx, fy);
    end

    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) check_output("pending_done", exp_q[l].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
